// File: rtl/sys_arr_pkg.sv
// Shared types and default dimensions for the systolic-array front end.
// The load sequencer and its interface import this package.
package sys_arr_pkg;

    localparam int SA_N  = 4;
    localparam int SA_DW = 16;
    localparam int SA_AW = 16;
    localparam int ROW_W = $clog2(SA_N);

    typedef enum logic [1:0] {
        WEIGHT  = 2'd0,
        INPUT   = 2'd1,
        PARTIAL = 2'd2,
        ILLEGAL = 2'd3
    } mat_type_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4
    } loadseq_state_t;

endpackage

// File: rtl/sys_arr_load_sequencer_if.sv
// Command, scratchpad and array-bus signals of the load sequencer.
// The slave modport is the sequencer; master is whoever drives it.
interface sys_arr_load_sequencer_if
    import sys_arr_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int DW = SA_DW,
    parameter int AW = SA_AW
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic            start;
    mat_type_t       mat_type;
    logic [AW-1:0]   base_addr;
    logic            busy;
    logic            done;
    logic            cmd_err;
    logic            mem_ren;
    logic [AW-1:0]   mem_addr;
    logic            mem_valid;
    logic [N*DW-1:0] mem_rdata;
    logic            fifo_has_space;
    logic            weight_en;
    logic            input_en;
    logic            partial_en;
    logic [RW-1:0]   row_in_en;
    logic [RW-1:0]   row_ps_en;
    logic [N*DW-1:0] array_bus;

    modport master (
        output start, mat_type, base_addr, mem_valid, mem_rdata, fifo_has_space,
        input  busy, done, cmd_err, mem_ren, mem_addr,
        input  weight_en, input_en, partial_en, row_in_en, row_ps_en, array_bus
    );

    modport slave (
        input  start, mat_type, base_addr, mem_valid, mem_rdata, fifo_has_space,
        output busy, done, cmd_err, mem_ren, mem_addr,
        output weight_en, input_en, partial_en, row_in_en, row_ps_en, array_bus
    );

endinterface

// File: rtl/sys_arr_load_sequencer.sv
// Fetches the N rows of one matrix from the scratchpad and presents each row
// on the array bus with its type strobe and row index, throttled by FIFO space.
module sys_arr_load_sequencer
    import sys_arr_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int DW = SA_DW,
    parameter int AW = SA_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    sys_arr_load_sequencer_if.slave  ctl_io
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_REQ   = REQ;
    localparam logic [2:0] S_WAIT  = WAIT;
    localparam logic [2:0] S_ISSUE = ISSUE;
    localparam logic [2:0] S_DONE  = DONE;

    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    logic [2:0]      state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    mat_type_t       type_q, type_d;
    logic [AW-1:0]   base_q, base_d;
    logic [N*DW-1:0] buf_q, buf_d;
    logic            cmd_err_q, cmd_err_d;

    logic go;
    logic issue;

    // Weight rows feed the MACs directly, so only input/partial rows wait on space.
    assign go    = (type_q == WEIGHT) | ctl_io.fifo_has_space;
    assign issue = (state_q == S_ISSUE) & go;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_d   = state_q;
        row_d     = row_q;
        type_d    = type_q;
        base_d    = base_q;
        buf_d     = buf_q;
        cmd_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctl_io.start) begin
                    if (ctl_io.mat_type == ILLEGAL) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        type_d  = ctl_io.mat_type;
                        base_d  = ctl_io.base_addr;
                        row_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ:   state_d = S_WAIT;
            S_WAIT: begin
                if (ctl_io.mem_valid) begin
                    buf_d   = ctl_io.mem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (go) begin
                    if (row_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            type_q    <= WEIGHT;
            base_q    <= '0;
            // NOTE: the row buffer is reset too, because array_bus must read 0 during reset.
            buf_q     <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            type_q    <= type_d;
            base_q    <= base_d;
            buf_q     <= buf_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign ctl_io.busy      = (state_q != S_IDLE);
    assign ctl_io.done      = (state_q == S_DONE);
    assign ctl_io.cmd_err   = cmd_err_q;
    assign ctl_io.mem_ren   = (state_q == S_REQ);
    assign ctl_io.mem_addr  = base_q + AW'(row_q);
    assign ctl_io.array_bus = buf_q;

    assign ctl_io.weight_en  = issue & (type_q == WEIGHT);
    assign ctl_io.input_en   = issue & (type_q == INPUT);
    assign ctl_io.partial_en = issue & (type_q == PARTIAL);

    // The index for the other row class stays at zero.
    assign ctl_io.row_in_en = (issue && type_q != PARTIAL) ? row_q : '0;
    assign ctl_io.row_ps_en = (issue && type_q == PARTIAL) ? row_q : '0;

endmodule

// File: tb/tb_sys_arr_load_sequencer.sv
// Bench for the load sequencer: command table, directed corner cases and a
// randomized run, all judged by a transaction-level model of the sequencer.
module tb_sys_arr_load_sequencer;
    import sys_arr_pkg::*;

    localparam int N  = SA_N;
    localparam int DW = SA_DW;
    localparam int AW = SA_AW;
    localparam int RW = ROW_W;
    localparam int BW = N * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sys_arr_load_sequencer_if #(.N(N), .DW(DW), .AW(AW)) lif();

    sys_arr_load_sequencer #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ctl_io (lif.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int salt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BW-1:0] row_data(input logic [AW-1:0] a);
        logic [BW-1:0] d;
        for (int e = 0; e < N; e++) d[e*DW +: DW] = DW'(a * 16'd31 + e * 977 + salt);
        return d;
    endfunction

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] d;
        for (int i = 0; i < BW; i++) d[i] = 1'($urandom_range(0, 1));
        return d;
    endfunction

    // Stimulus controls
    logic          d_start = 1'b0;
    logic [1:0]    d_type  = 2'd0;
    logic [AW-1:0] d_base  = '0;
    int            lat        = 1;
    int            space_mode = 0;   // 0: always space, 1: never space, 2: random
    int            lo_from    = -1;
    int            lo_to      = -1;
    bit            junk_en    = 1'b0;

    // Scratchpad model: outstanding reads with their due cycle
    int            pend_due[$];
    logic [AW-1:0] pend_addr[$];

    // Reference model of the sequencer at transaction level
    bit            m_busy, m_req_due, m_wait, m_ready, m_done_due, m_err_due;
    logic [1:0]    m_type;
    logic [AW-1:0] m_base;
    int            m_row;
    logic [BW-1:0] m_data;
    int            n_accept, n_done;

    // Observed events
    int            stb_cyc[$];
    logic [AW-1:0] rd_addr[$];
    int            done_cyc, err_cyc;

    task automatic model_reset();
        m_busy = 0; m_req_due = 0; m_wait = 0; m_ready = 0; m_done_due = 0; m_err_due = 0;
        m_type = 2'd0; m_base = '0; m_row = 0; m_data = '0;
        pend_due.delete(); pend_addr.delete();
    endtask

    task automatic clear_rec();
        stb_cyc.delete(); rd_addr.delete();
        done_cyc = -1; err_cyc = -1;
    endtask

    task automatic cycle();
        bit            was_busy;
        logic          exp_ren, exp_stb;
        logic [2:0]    exp_kind, act_kind;
        logic [RW-1:0] exp_in, exp_ps;
        logic [AW-1:0] exp_addr;
        @(posedge clk);
        cyc++;
        #1;
        lif.start     = d_start;
        lif.mat_type  = mat_type_t'(d_type);
        lif.base_addr = d_base;
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
            lif.mem_valid = 1'b1;
            lif.mem_rdata = row_data(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end else begin
            lif.mem_rdata = rand_bus();
            lif.mem_valid = junk_en && !m_wait && pend_due.size() == 0 && $urandom_range(0, 3) == 0;
        end
        if (cyc >= lo_from && cyc <= lo_to) lif.fifo_has_space = 1'b0;
        else if (space_mode == 0)           lif.fifo_has_space = 1'b1;
        else if (space_mode == 1)           lif.fifo_has_space = 1'b0;
        else                                lif.fifo_has_space = ($urandom_range(0, 3) != 0);
        @(negedge clk);

        exp_ren  = m_req_due;
        exp_stb  = m_ready && (m_type == WEIGHT || lif.fifo_has_space);
        exp_kind = exp_stb ? (3'b001 << m_type) : 3'b000;
        exp_in   = (exp_stb && m_type != PARTIAL) ? RW'(m_row) : '0;
        exp_ps   = (exp_stb && m_type == PARTIAL) ? RW'(m_row) : '0;
        exp_addr = m_base + AW'(m_row);
        act_kind = {lif.partial_en, lif.input_en, lif.weight_en};

        check("busy", lif.busy, m_busy);
        check("done", lif.done, m_done_due);
        check("cmd_err", lif.cmd_err, m_err_due);
        check("mem_ren", lif.mem_ren, exp_ren);
        if (exp_ren) check("mem_addr", lif.mem_addr, exp_addr);
        check("strobes", act_kind, exp_kind);
        check("row_in_en", lif.row_in_en, exp_in);
        check("row_ps_en", lif.row_ps_en, exp_ps);
        if (exp_stb) check("array_bus", lif.array_bus, m_data);

        if (lif.mem_ren) begin
            pend_due.push_back(cyc + lat);
            pend_addr.push_back(lif.mem_addr);
            rd_addr.push_back(lif.mem_addr);
        end
        if (act_kind != 3'b000) stb_cyc.push_back(cyc);
        if (lif.done)    begin done_cyc = cyc; n_done++; end
        if (lif.cmd_err) err_cyc = cyc;

        was_busy = m_busy;
        if (m_done_due) m_busy = 0;
        m_done_due = 0;
        m_err_due  = 0;
        if (m_wait && lif.mem_valid) begin
            m_wait  = 0;
            m_ready = 1;
            m_data  = lif.mem_rdata;
        end
        if (exp_ren) begin
            m_req_due = 0;
            m_wait    = 1;
        end
        if (exp_stb) begin
            m_ready = 0;
            if (m_row == N - 1) m_done_due = 1;
            else begin m_row++; m_req_due = 1; end
        end
        if (!was_busy && lif.start) begin
            if (lif.mat_type == ILLEGAL) m_err_due = 1;
            else begin
                m_busy = 1; m_type = lif.mat_type; m_base = lif.base_addr;
                m_row = 0; m_req_due = 1; n_accept++;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        for (int t = 0; t < budget && done_cyc < 0; t++) cycle();
        check("done_seen", done_cyc >= 0, 1'b1);
    endtask

    // Issues one command and returns the cycle in which start was driven.
    task automatic send_cmd(input logic [1:0] mt, input logic [AW-1:0] base, output int k);
        d_start = 1'b1; d_type = mt; d_base = base;
        k = cyc + 1;
        cycle();
        d_start = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    mtype;
        logic [AW-1:0] base;
        int            lat;
        int            space;
        bit            exp_err;
        int            exp_done;   // -1: not timed
        int            exp_stb0;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        salt = int'($urandom_range(0, 65535));
        vecs[0] = '{2'd0, 16'h0010, 1, 1, 1'b0, 13, 3, 16'h0010, 16'h0013};
        vecs[1] = '{2'd1, 16'h0100, 1, 0, 1'b0, 13, 3, 16'h0100, 16'h0103};
        vecs[2] = '{2'd2, 16'h0200, 3, 0, 1'b0, 21, 5, 16'h0200, 16'h0203};
        vecs[3] = '{2'd1, 16'h0300, 2, 0, 1'b0, 17, 4, 16'h0300, 16'h0303};
        vecs[4] = '{2'd3, 16'h0400, 1, 0, 1'b1, -1, -1, 16'h0000, 16'h0000};
        vecs[5] = '{2'd0, 16'hFFFE, 1, 0, 1'b0, 13, 3, 16'hFFFE, 16'h0001};
        vecs[6] = '{2'd2, 16'h1234, 1, 2, 1'b0, -1, -1, 16'h1234, 16'h1237};

        // Reset state
        rst = 1'b1;
        lif.start = 1'b0; lif.mat_type = WEIGHT; lif.base_addr = '0;
        lif.mem_valid = 1'b0; lif.mem_rdata = '0; lif.fifo_has_space = 1'b0;
        model_reset();
        clear_rec();
        n_accept = 0; n_done = 0;
        #1;
        check("reset_ctl", {lif.busy, lif.done, lif.cmd_err, lif.mem_ren,
                            lif.weight_en, lif.input_en, lif.partial_en}, 7'd0);
        check("reset_idx", {lif.row_in_en, lif.row_ps_en}, '0);
        check("reset_addr", lif.mem_addr, '0);
        check("reset_bus", lif.array_bus, '0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Command table
        for (int i = 0; i < 7; i++) begin
            clear_rec();
            lat = vecs[i].lat;
            space_mode = vecs[i].space;
            send_cmd(vecs[i].mtype, vecs[i].base, k);
            if (vecs[i].exp_err) begin
                repeat (4) cycle();
                check("err_offset", err_cyc - k, 1);
                check("err_no_strobe", stb_cyc.size(), 0);
                check("err_no_read", rd_addr.size(), 0);
            end else begin
                wait_done(400);
                check("strobe_count", stb_cyc.size(), N);
                check("read_count", rd_addr.size(), N);
                if (rd_addr.size() == N) begin
                    check("first_addr", rd_addr[0], vecs[i].exp_first);
                    check("last_addr", rd_addr[N-1], vecs[i].exp_last);
                end
                if (vecs[i].exp_done >= 0) begin
                    check("done_offset", done_cyc - k, vecs[i].exp_done);
                    if (stb_cyc.size() == N) begin
                        check("strobe0_offset", stb_cyc[0] - k, vecs[i].exp_stb0);
                        for (int r = 1; r < N; r++)
                            check("strobe_spacing", stb_cyc[r] - stb_cyc[r-1], vecs[i].lat + 2);
                    end
                end
            end
        end

        // Input load with five cycles of backpressure on row 2
        clear_rec();
        lat = 1; space_mode = 0;
        lo_from = cyc + 1 + 9;
        lo_to   = cyc + 1 + 13;
        send_cmd(2'd1, 16'h0500, k);
        for (int t = 0; t < 400 && done_cyc < 0; t++) begin
            cycle();
            if (cyc >= k + 9 && cyc <= k + 13)
                check("bp_bus_hold", lif.array_bus, row_data(16'h0502));
        end
        lo_from = -1; lo_to = -1;
        check("bp_done_seen", done_cyc >= 0, 1'b1);
        check("bp_reads", rd_addr.size(), N);
        if (stb_cyc.size() == N) check("bp_row2_delay", stb_cyc[2] - k, 14);
        check("bp_done_offset", done_cyc - k, 18);

        // Starts during an active load are ignored
        clear_rec();
        send_cmd(2'd0, 16'h0600, k);
        repeat (3) cycle();
        d_start = 1'b1; d_type = 2'd2; d_base = 16'h0700;
        cycle();
        d_type = 2'd3;
        cycle();
        d_start = 1'b0;
        wait_done(400);
        check("ovl_strobes", stb_cyc.size(), N);
        check("ovl_no_err", err_cyc, -1);
        check("ovl_done_offset", done_cyc - k, 13);
        if (rd_addr.size() == N)
            for (int r = 0; r < N; r++) check("ovl_addr", rd_addr[r], 16'h0600 + 16'(r));

        // Asynchronous reset while waiting for row 1 data
        clear_rec();
        lat = 3;
        send_cmd(2'd1, 16'h0800, k);
        repeat (7) cycle();
        @(posedge clk);
        cyc++;
        #1;
        lif.start = 1'b0; lif.mem_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ctl", {lif.busy, lif.done, lif.cmd_err, lif.mem_ren,
                                lif.weight_en, lif.input_en, lif.partial_en}, 7'd0);
        check("rst_async_idx", {lif.row_in_en, lif.row_ps_en}, '0);
        check("rst_async_addr", lif.mem_addr, '0);
        check("rst_async_bus", lif.array_bus, '0);
        model_reset();
        clear_rec();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) cycle();
        check("rst_no_done", done_cyc, -1);
        check("rst_no_strobe", stb_cyc.size(), 0);
        check("rst_no_read", rd_addr.size(), 0);
        clear_rec();
        lat = 1;
        send_cmd(2'd2, 16'h0900, k);
        wait_done(400);
        check("post_rst_done_offset", done_cyc - k, 13);

        // Randomized commands, latencies, space, spurious valids and stray starts
        n_accept = 0; n_done = 0;
        space_mode = 2; junk_en = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if (!m_busy && pend_due.size() == 0) lat = int'($urandom_range(1, 4));
            d_start = m_busy ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
            d_type  = 2'($urandom_range(0, 3));
            d_base  = AW'($urandom);
            cycle();
        end
        d_start = 1'b0; junk_en = 1'b0;
        for (int t = 0; t < 400 && m_busy; t++) cycle();
        cycle();
        check("rand_drained", lif.busy, 1'b0);
        check("rand_done_count", n_done, n_accept);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
